// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered UART transmit channel.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;
  localparam int unsigned DEFAULT_BAUD     = 9600;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: latches a byte on start and shifts it out LSB first.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD     = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = $clog2(BIT_CYC);
  localparam int unsigned IDX_W   = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [8:0]       shreg;
  logic             load, advance;

  assign busy = (state_q == SER_SEND);

  // State register; a reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SER_IDLE;
    else       state_q <= state_d;
  end

  // Next state: accept start only when idle, finish after the stop bit.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (start) begin
          state_d = SER_SEND;
          load    = 1'b1;
        end
      end
      SER_SEND: begin
        if (bit_cnt == CNT_LAST) begin
          if (bit_idx == IDX_LAST) state_d = SER_IDLE;
          else                     advance = 1'b1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // Bit timing and line driver; txd rests high outside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else if (load) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      txd     <= 1'b0;
    end else if (busy) begin
      if (bit_cnt == CNT_LAST) begin
        bit_cnt <= '0;
        if (advance) begin
          bit_idx <= bit_idx + 1'b1;
          txd     <= shreg[0];
        end else begin
          txd     <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Shift register holds the remaining data bits with the stop bit behind them.
  always_ff @(posedge clk) begin
    if (load)         shreg <= {1'b1, data};
    else if (advance) shreg <= {1'b1, shreg[8:1]};
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmit channel: registered push path, FIFO, pop/start handshake, serializer.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD       = DEFAULT_BAUD,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  input  logic       uart_txd_enable,
  input  logic [7:0] uart_txd_data,
  output logic       uart_txd,
  output logic       zero,
  output logic [7:0] size
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic          unused_rxd;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    size_q;
  logic [7:0]    hold;
  logic          full, empty, do_wr;
  logic          pop, start, pop_ready, pop_set;
  logic          busy;

  // Receive pin is reserved for a future receiver.
  assign unused_rxd = uart_rxd;

  assign size    = size_q;
  assign full    = (size_q == 8'(FIFO_DEPTH));
  assign empty   = (size_q == 8'd0);
  assign do_wr   = wr_en & ~full;
  assign pop_set = ~busy & ~empty & ~pop & pop_ready;

  // Push stage: capture the host strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_en <= 1'b0;
    else       wr_en <= uart_txd_enable;
  end

  // Push stage data, no reset needed.
  always_ff @(posedge clk) begin
    wr_data <= uart_txd_data;
  end

  // FIFO pointers and occupancy; a push while full is silently dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size_q <= 8'd0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, pop})
        2'b10:   size_q <= size_q + 8'd1;
        2'b01:   size_q <= size_q - 8'd1;
        default: size_q <= size_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Holding register feeding the serializer.
  always_ff @(posedge clk) begin
    if (pop) hold <= mem[rd_ptr];
  end

  // Drain handshake: pop_ready blocks a second pop until the serializer is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop       <= 1'b0;
      start     <= 1'b0;
      pop_ready <= 1'b1;
      zero      <= 1'b0;
    end else begin
      pop   <= pop_set;
      start <= pop;
      zero  <= start & (hold == 8'h00);
      if (pop_set)   pop_ready <= 1'b0;
      else if (busy) pop_ready <= 1'b1;
    end
  end

  uart_tx_serializer #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_ser (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (hold),
    .txd   (uart_txd),
    .busy  (busy)
  );

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered with a behavioural line decoder.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 100;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 16;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int LAT      = 4;  // strobe edge to first start-bit cycle

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         k;
    logic       txd;
    logic [7:0] size;
    logic       zero;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       uart_txd_enable;
  logic [7:0] uart_txd_data;
  logic       uart_txd;
  logic       zero;
  logic [7:0] size;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .uart_rxd        (uart_rxd),
    .uart_txd_enable (uart_txd_enable),
    .uart_txd_data   (uart_txd_data),
    .uart_txd        (uart_txd),
    .zero            (zero),
    .size            (size)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Line decoder: finds start bits, samples mid-bit, collects bytes.
  logic [7:0] rx_q[$];
  int         gaps[$];
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         last_end = -100000;
  int         mon_st;
  logic [7:0] mon_b;
  int         frame_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_txd === 1'b0) begin
        mon_st = cyc;
        gaps.push_back(mon_st - last_end);
        repeat (BIT / 2) @(negedge clk);
        if (uart_txd !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = uart_txd;
        end
        repeat (BIT) @(negedge clk);
        if (uart_txd !== 1'b1) frame_err++;
        rx_q.push_back(mon_b);
        last_end = mon_st + 10 * BIT;
      end
    end
  end

  // Zero-pulse, occupancy-peak and double-pop observers.
  int zero_cnt = 0;
  int zero_idx = -1;
  int peak     = 0;
  int dbl_pop  = 0;
  bit pop_pend = 1'b0;

  always @(negedge clk) begin
    if (zero === 1'b1) begin
      zero_cnt++;
      zero_idx = rx_q.size();
    end
    if (int'(size) > peak) peak = int'(size);
    if (reset || dut.busy) pop_pend = 1'b0;
    if (dut.pop === 1'b1) begin
      if (pop_pend) dbl_pop++;
      pop_pend = 1'b1;
    end
  end

  // Expected line level j cycles into a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    int p;
    if (j < 0) return 1'b1;
    p = j / BIT;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    uart_txd_enable = 1'b1;
    uart_txd_data   = b;
    @(negedge clk);
    uart_txd_enable = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    checki("rx_wait_count", (rx_q.size() >= n) ? n : rx_q.size(), n);
  endtask

  task automatic cmp_stream(input string nm, input bq_t e);
    checki({nm, "_count"}, rx_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      check8(nm, (i < rx_q.size()) ? rx_q[i] : 8'hxx, e[i]);
  endtask

  vec_t       tv[19];
  bq_t        exp_q;
  logic [7:0] burst[7];
  int         bad;

  initial begin
    tv = '{
      '{0,   1'b1, 8'd0, 1'b0}, '{1,   1'b1, 8'd1, 1'b0}, '{2,   1'b1, 8'd1, 1'b0},
      '{3,   1'b1, 8'd0, 1'b0}, '{4,   1'b0, 8'd0, 1'b0}, '{13,  1'b0, 8'd0, 1'b0},
      '{14,  1'b0, 8'd0, 1'b0}, '{23,  1'b0, 8'd0, 1'b0}, '{24,  1'b1, 8'd0, 1'b0},
      '{33,  1'b1, 8'd0, 1'b0}, '{34,  1'b0, 8'd0, 1'b0}, '{73,  1'b0, 8'd0, 1'b0},
      '{74,  1'b1, 8'd0, 1'b0}, '{83,  1'b1, 8'd0, 1'b0}, '{84,  1'b0, 8'd0, 1'b0},
      '{93,  1'b0, 8'd0, 1'b0}, '{94,  1'b1, 8'd0, 1'b0}, '{103, 1'b1, 8'd0, 1'b0},
      '{104, 1'b1, 8'd0, 1'b0}
    };
    burst = '{8'h69, 8'h97, 8'h20, 8'h88, 8'h77, 8'h61, 8'h00};

    reset = 1'b1;
    uart_rxd = 1'b1;
    uart_txd_enable = 1'b0;
    uart_txd_data = 8'h00;

    // Reset values and idle observation.
    repeat (3) @(negedge clk);
    check1("rst_txd", uart_txd, 1'b1);
    check8("rst_size", size, 8'd0);
    check1("rst_zero", zero, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check1("idle_txd", uart_txd, 1'b1);
      check8("idle_size", size, 8'd0);
      check1("idle_zero", zero, 1'b0);
    end

    // Asynchronous reset in the middle of a frame.
    push(8'hA5);
    push(8'h3C);
    repeat (40) @(negedge clk);
    check1("midframe_line_low_or_data", (size == 8'd1), 1'b1);
    #2 reset = 1'b1;
    #1;
    check1("abort_txd", uart_txd, 1'b1);
    check8("abort_size", size, 8'd0);
    check1("abort_zero", zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) bad++;
    end
    checki("post_abort_quiet_cycles_low", bad, 0);
    check8("post_abort_size", size, 8'd0);
    mon_en = 1'b1;

    // Single byte 0x42: vector table plus frame arithmetic per cycle.
    uart_txd_enable = 1'b1;
    uart_txd_data   = 8'h42;
    for (int k = 0; k <= 110; k++) begin
      @(negedge clk);
      if (k == 0) uart_txd_enable = 1'b0;
      foreach (tv[i]) begin
        if (tv[i].k == k) begin
          check1("vec_txd", uart_txd, tv[i].txd);
          check8("vec_size", size, tv[i].size);
          check1("vec_zero", zero, tv[i].zero);
        end
      end
      check1("frame_42", uart_txd, frame_bit(8'h42, k - LAT));
    end
    exp_q = '{8'h42};
    cmp_stream("single_byte", exp_q);

    // Burst on alternating cycles including a 0x00 byte.
    rx_q.delete();
    gaps.delete();
    zero_cnt = 0;
    zero_idx = -1;
    peak     = 0;
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      push(burst[i]);
      exp_q.push_back(burst[i]);
      @(negedge clk);
    end
    wait_rx(7, 1500);
    cmp_stream("burst", exp_q);
    checki("burst_zero_pulses", zero_cnt, 1);
    checki("burst_zero_frame_index", zero_idx, 6);
    check1("burst_peak_6_or_7", (peak == 6 || peak == 7), 1'b1);
    for (int i = 1; i < gaps.size(); i++)
      check1("burst_gap_le_4", (gaps[i] <= 4), 1'b1);
    check8("burst_size_end", size, 8'd0);

    // Overflow: DEPTH+3 pushes while the serializer is busy.
    rx_q.delete();
    exp_q.delete();
    uart_txd_data = 8'($urandom);
    exp_q.push_back(uart_txd_data);
    push(uart_txd_data);
    repeat (8) @(negedge clk);
    for (int i = 0; i < DEPTH + 3; i++) begin
      uart_txd_enable = 1'b1;
      uart_txd_data   = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(uart_txd_data);
      @(negedge clk);
    end
    uart_txd_enable = 1'b0;
    repeat (2) @(negedge clk);
    check8("overflow_size_sat", size, 8'(DEPTH));
    wait_rx(DEPTH + 1, (DEPTH + 1) * 110 + 200);
    repeat (300) @(negedge clk);
    cmp_stream("overflow", exp_q);
    check8("overflow_size_end", size, 8'd0);

    // Push in the last cycle of a frame, then into an idle empty channel.
    rx_q.delete();
    dbl_pop = 0;
    push(8'h5A);
    repeat (LAT + 10 * BIT - 2) @(negedge clk);
    push(8'hC3);
    wait_rx(2, 400);
    repeat (200) @(negedge clk);
    push(8'h0F);
    wait_rx(3, 300);
    repeat (300) @(negedge clk);
    exp_q = '{8'h5A, 8'hC3, 8'h0F};
    cmp_stream("edge_pushes", exp_q);
    checki("double_pop_events", dbl_pop, 0);

    // Randomized bytes and gaps against the in-order reference queue.
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      uart_txd_data = 8'($urandom);
      exp_q.push_back(uart_txd_data);
      push(uart_txd_data);
      repeat ($urandom_range(150, 1)) @(negedge clk);
    end
    wait_rx(10, 1500);
    repeat (150) @(negedge clk);
    cmp_stream("random", exp_q);
    checki("framing_errors", frame_err, 0);
    checki("double_pop_total", dbl_pop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
